// File: rtl/bitcnt_pkg.sv
// Shared types for the bit-count execution unit: operation encoding and default widths.
package bitcnt_pkg;

   localparam int BC_XLEN  = 32;
   localparam int BC_TAG_W = 5;

   typedef enum logic [1:0] {
      BC_CTZ  = 2'b00,
      BC_CLZ  = 2'b01,
      BC_CPOP = 2'b10,
      BC_RSVD = 2'b11
   } bc_op_e;

endpackage

// File: rtl/bitcnt_if.sv
// Issue-side and writeback-side handshake bundle of the bit-count unit.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready;
// the sender keeps valid and data stable until then and never derives valid from ready.
interface bitcnt_if
   import bitcnt_pkg::*;
#(
   parameter int XLEN  = BC_XLEN,
   parameter int TAG_W = BC_TAG_W
);
   logic             in_valid;
   logic             in_ready;
   bc_op_e           in_op;
   logic [XLEN-1:0]  in_opnd;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_result;
   logic [TAG_W-1:0] out_tag;
   logic             out_illegal;

   modport master (
      output in_valid, in_op, in_opnd, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag, out_illegal
   );

   modport slave (
      input  in_valid, in_op, in_opnd, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag, out_illegal
   );
endinterface

// File: rtl/bitcnt_exec_lowbit_index.sv
// Trailing-zero core: isolates the lowest set bit and encodes its position with an OR tree.
module lowbit_index #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]         x_i,
   output logic [$clog2(XLEN)-1:0] idx_o,
   output logic                    zero_o
);
   localparam int IW = $clog2(XLEN);

   logic [XLEN-1:0] iso;

   assign iso    = x_i & (-x_i);
   assign zero_o = ~|x_i;

   // Index bit b is the OR of every one-hot position whose binary index has bit b set.
   always_comb begin
      idx_o = '0;
      for (int b = 0; b < IW; b++) begin
         for (int i = 0; i < XLEN; i++) begin
            if (((i >> b) & 1) == 1) idx_o[b] = idx_o[b] | iso[i];
         end
      end
   end
endmodule

// File: rtl/bitcnt_exec.sv
// Two-stage CTZ/CLZ/CPOP execution unit with flush; CLZ runs on the bit-reversed operand.
// Define BITCNT_CPOP_EN to build population count; otherwise CPOP is reported illegal.
module bitcnt_exec
   import bitcnt_pkg::*;
#(
   parameter int XLEN  = BC_XLEN,
   parameter int TAG_W = BC_TAG_W
) (
   input logic     clk,
   input logic     rst_n,
   input logic     flush,
   bitcnt_if.slave bus
);
   localparam int IW = $clog2(XLEN);
   localparam int CW = IW + 1;

   typedef struct packed {
      logic             valid;
      bc_op_e           op;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  opnd;
      logic             zero;
   } stage_t;

   stage_t           s1_q, s1_d;
   logic             s2_valid_q, s2_valid_d;
   logic [XLEN-1:0]  res_q, res_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             ill_q, ill_d;

   logic             s2_ready, in_ready;
   logic [XLEN-1:0]  prep;
   logic [IW-1:0]    lb_idx;
   logic             lb_zero;
   logic [CW-1:0]    cnt;
   logic             ill;

   assign s2_ready = !s2_valid_q || bus.out_ready;
   assign in_ready = !flush && (!s1_q.valid || s2_ready);

   always_comb begin
      prep = bus.in_opnd;
      if (bus.in_op == BC_CLZ) begin
         for (int i = 0; i < XLEN; i++) prep[i] = bus.in_opnd[XLEN-1-i];
      end
   end

   lowbit_index #(.XLEN(XLEN)) u_lowbit (
      .x_i    (s1_q.opnd),
      .idx_o  (lb_idx),
      .zero_o (lb_zero)
   );

`ifdef BITCNT_CPOP_EN
   logic [CW-1:0] pop;
   always_comb begin
      pop = '0;
      for (int i = 0; i < XLEN; i++) pop = pop + CW'(s1_q.opnd[i]);
   end
`endif

   always_comb begin
      cnt = '0;
      ill = 1'b0;
      case (s1_q.op)
         BC_CTZ, BC_CLZ: cnt = (s1_q.zero || lb_zero) ? CW'(XLEN) : {1'b0, lb_idx};
`ifdef BITCNT_CPOP_EN
         BC_CPOP:        cnt = pop;
`endif
         default:        ill = 1'b1;
      endcase
   end

   // Stage 1 moves whenever it can accept; stage 2 holds while writeback stalls.
   always_comb begin
      s1_d       = s1_q;
      s2_valid_d = s2_valid_q;
      res_d      = res_q;
      tag_d      = tag_q;
      ill_d      = ill_q;
      if (flush) begin
         s1_d.valid = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (s2_ready) begin
            s2_valid_d = s1_q.valid;
            if (s1_q.valid) begin
               res_d = {{(XLEN-CW){1'b0}}, cnt};
               tag_d = s1_q.tag;
               ill_d = ill;
            end
         end
         if (in_ready) begin
            s1_d.valid = bus.in_valid;
            if (bus.in_valid) begin
               s1_d.op   = bus.in_op;
               s1_d.tag  = bus.in_tag;
               s1_d.opnd = prep;
               s1_d.zero = ~|bus.in_opnd;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q       <= '0;
         s2_valid_q <= 1'b0;
         res_q      <= '0;
         tag_q      <= '0;
         ill_q      <= 1'b0;
      end else begin
         s1_q       <= s1_d;
         s2_valid_q <= s2_valid_d;
         res_q      <= res_d;
         tag_q      <= tag_d;
         ill_q      <= ill_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = s2_valid_q;
   assign bus.out_result  = res_q;
   assign bus.out_tag     = tag_q;
   assign bus.out_illegal = ill_q;
endmodule
